prog_mem_loader_arb: RTL

Loader and arbiter for the processor's single-port program memory. Decodes the byte stream delivered by the I2C programming slave into halt/run/write commands. Buffers program writes and shares the memory port with the processor's instruction-fetch unit using fetch priority plus a starvation guard. Sits between the I2C slave, the program memory and the processor core inside the top-level wrapper.

---
 rtl/prog_mem_loader_arb_if.sv | 24 ++
 rtl/prog_mem_loader_arb.sv | 90 +++++++++
 2 files changed

// File: rtl/prog_mem_loader_arb_if.sv
// prog_mem_loader_arb_if: I2C byte stream, fetch port and program memory port bundle
interface prog_mem_loader_arb_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
);
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_stop;
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_gnt;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  modport master (
    output rx_valid, rx_data, rx_stop, fetch_req, fetch_addr,
    input  fetch_gnt, mem_en, mem_we, mem_addr, mem_wdata
  );
  modport slave (
    input  rx_valid, rx_data, rx_stop, fetch_req, fetch_addr,
    output fetch_gnt, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/prog_mem_loader_arb.sv
// prog_mem_loader_arb: I2C command decoder and program memory arbiter; PROG_CHECKSUM_EN adds the write checksum
module prog_mem_loader_arb #(
  parameter int ADDR_W     = 5,
  parameter int DATA_W     = 8,
  parameter int STARVE_MAX = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  prog_mem_loader_arb_if.slave bus,
  output logic                 cpu_halt,
  output logic                 cpu_rst,
  output logic                 busy,
  output logic                 err,
  output logic [7:0]           checksum
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  typedef enum logic [1:0] {IDLE, GET_ADDR, WRITE_DATA} state_t;
  state_t            state, state_n;
  logic              buf_full;
  logic [ADDR_W-1:0] buf_addr, ptr;
  logic [DATA_W-1:0] buf_data;
  logic [SW-1:0]     starve;
  logic              wr_win, gnt, is_cmd, is_addr, is_data, accept, overrun;
  always_comb begin
    wr_win   = buf_full && (cpu_halt || !bus.fetch_req || starve == SW'(STARVE_MAX));
    gnt      = !wr_win && bus.fetch_req && !cpu_halt;
    is_cmd   = bus.rx_valid && state == IDLE;
    is_addr  = bus.rx_valid && state == GET_ADDR;
    is_data  = bus.rx_valid && state == WRITE_DATA;
    // the single buffer slot may be refilled on the same edge it drains
    accept   = is_data && (!buf_full || wr_win);
    overrun  = is_data && !accept;
    state_n  = bus.rx_stop ? IDLE :
               !bus.rx_valid ? state :
               state == IDLE ? (bus.rx_data == 8'hA0 ? GET_ADDR : IDLE) : WRITE_DATA;
  end
  assign bus.fetch_gnt = gnt;
  assign bus.mem_en    = wr_win || gnt;
  assign bus.mem_we    = wr_win;
  assign bus.mem_addr  = wr_win ? buf_addr : bus.fetch_addr;
  assign bus.mem_wdata = buf_data;
  assign busy          = buf_full;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_halt <= 1'b1;
      cpu_rst  <= 1'b0;
      err      <= 1'b0;
      buf_full <= 1'b0;
      buf_addr <= '0;
      buf_data <= '0;
      ptr      <= '0;
      starve   <= '0;
    end else begin
      cpu_rst <= 1'b0;
      if (is_cmd) begin
        if (bus.rx_data == 8'hA1) cpu_halt <= 1'b1;
        else if (bus.rx_data == 8'hA2) begin
          cpu_halt <= 1'b0;
          cpu_rst  <= 1'b1;
        end
        else if (bus.rx_data == 8'hA3) err <= 1'b0;
        else if (bus.rx_data != 8'hA0) err <= 1'b1;
      end
      if (is_addr) ptr <= bus.rx_data[ADDR_W-1:0];
      if (overrun) err <= 1'b1;
      if (wr_win) begin
        buf_full <= 1'b0;
        starve   <= '0;
      end
      else if (buf_full && gnt) starve <= starve + SW'(1);
      if (accept) begin
        buf_full <= 1'b1;
        buf_addr <= ptr;
        buf_data <= bus.rx_data[DATA_W-1:0];
        ptr      <= ptr + ADDR_W'(1);
      end
    end
  end
`ifdef PROG_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) checksum <= '0;
    else checksum <= (is_cmd && bus.rx_data == 8'hA0) ? 8'h00 :
                     wr_win ? checksum + buf_data : checksum;
`else
  assign checksum = '0;
`endif
endmodule
